// File: rtl/branch_predictor_q.sv
// Saturating-counter branch predictor with an in-order outstanding-branch queue.
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor_q #(
    parameter int IDX_W = 6,
    parameter int CNT_W = 2,
    parameter int Q_W   = 3,
    parameter int GHR_W = 6
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          pred_valid,
    input  logic [31:0]   pred_pc,
    input  logic [31:0]   pred_imm,
    input  logic          pred_len,
    output logic          pred_ready,
    output logic          need_branch,
    output logic [31:0]   branch_addr,
    input  logic          cdb_active,
    input  logic [31:0]   cdb_addr,
    input  logic [31:0]   cdb_val,
    output logic          predict_fail,
    output logic [31:0]   fail_addr,
    output logic [Q_W:0]  q_count
);

    localparam int              DEPTH    = 1 << Q_W;
    localparam int              BHT      = 1 << IDX_W;
    localparam logic [Q_W:0]    FULL     = (Q_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CTR_INIT = CNT_W'((1 << (CNT_W-1)) - 1);
    localparam logic [CNT_W-1:0] CTR_MAX  = '1;

    function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] c, input logic up);
        if (up)
            return (c == CTR_MAX) ? c : c + CNT_W'(1);
        else
            return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] ctr [BHT];

    logic [31:0]      q_pc   [DEPTH];
    logic [31:0]      q_alt  [DEPTH];
    logic             q_pred [DEPTH];
    logic [IDX_W-1:0] q_idx  [DEPTH];

    logic [Q_W-1:0]   front, rear;
    logic [IDX_W-1:0] idx;
    logic             taken, push, resolve, fail;
    logic [31:0]      seq_addr, tgt_addr, alt_addr;
    logic             unused_cdb_bits;

    assign unused_cdb_bits = ^cdb_val[31:1];

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr;
    assign idx = pred_pc[IDX_W:1] ^ IDX_W'(ghr);
`else
    localparam int unused_ghr_w = GHR_W;
    assign idx = pred_pc[IDX_W:1];
`endif

    assign pred_ready = (q_count != FULL);
    assign push       = rdy_in & pred_valid & pred_ready;
    assign taken      = ctr[idx][CNT_W-1];
    assign seq_addr   = pred_pc + (pred_len ? 32'd4 : 32'd2);
    assign tgt_addr   = pred_pc + pred_imm;
    assign alt_addr   = taken ? seq_addr : tgt_addr;

    assign need_branch = push & taken;
    assign branch_addr = push ? (taken ? tgt_addr : seq_addr) : 32'd0;

    // Resolution only ever looks at the oldest outstanding branch.
    assign resolve      = rdy_in & cdb_active & (q_count != '0) & (cdb_addr == q_pc[front]);
    assign fail         = resolve & (q_pred[front] != cdb_val[0]);
    assign predict_fail = fail;
    assign fail_addr    = fail ? q_alt[front] : 32'd0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            front   <= '0;
            rear    <= '0;
            q_count <= '0;
            for (int i = 0; i < BHT; i++)
                ctr[i] <= CTR_INIT;
`ifdef BP_GSHARE_EN
            ghr     <= '0;
`endif
        end else if (rdy_in) begin
            if (resolve) begin
                ctr[q_idx[front]] <= sat_update(ctr[q_idx[front]], cdb_val[0]);
`ifdef BP_GSHARE_EN
                ghr <= GHR_W'({ghr, cdb_val[0]});
`endif
            end
            // A mispredict squashes everything younger, including a same-cycle push.
            if (fail) begin
                front   <= '0;
                rear    <= '0;
                q_count <= '0;
            end else begin
                if (push)
                    rear <= rear + Q_W'(1);
                if (resolve)
                    front <= front + Q_W'(1);
                case ({push, resolve})
                    2'b10:   q_count <= q_count + (Q_W+1)'(1);
                    2'b01:   q_count <= q_count - (Q_W+1)'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push && !fail) begin
            q_pc[rear]   <= pred_pc;
            q_alt[rear]  <= alt_addr;
            q_pred[rear] <= taken;
            q_idx[rear]  <= idx;
        end
    end

endmodule
